// File: rtl/ili9341_pkg.sv
// rtl/ili9341_pkg.sv - mood codes, palette, pattern modes and FSM encoding for the ILI9341 frame generator
package ili9341_pkg;

   localparam int MOOD_IDLE      = 0;
   localparam int MOOD_TRISTE    = 1;
   localparam int MOOD_CARINO    = 2;
   localparam int MOOD_DEPRIMIDO = 3;
   localparam int MOOD_MUERTO    = 4;

   localparam logic [15:0] COLOR_IDLE      = 16'hFFE0;
   localparam logic [15:0] COLOR_TRISTE    = 16'h07FF;
   localparam logic [15:0] COLOR_CARINO    = 16'hF800;
   localparam logic [15:0] COLOR_DEPRIMIDO = 16'h780F;
   localparam logic [15:0] COLOR_MUERTO    = 16'h0000;

   // Entry i is the colour of mood code i.
   localparam logic [4:0][15:0] PALETTE = {COLOR_MUERTO, COLOR_DEPRIMIDO, COLOR_CARINO,
                                           COLOR_TRISTE, COLOR_IDLE};

   localparam logic [15:0] DEFAULT_COLOR = 16'h001F;

   localparam logic [1:0] MODE_SOLID   = 2'd0;
   localparam logic [1:0] MODE_STRIPES = 2'd1;
   localparam logic [1:0] MODE_CHECKER = 2'd2;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   function automatic logic [15:0] mood_color(input int unsigned sel, input int unsigned num_images);
      logic [2:0] idx;
      if (sel >= num_images || sel > MOOD_MUERTO)
         return DEFAULT_COLOR;
      idx = sel[2:0];
      return PALETTE[idx];
   endfunction

endpackage

// File: rtl/ili9341_pixel_cursor.sv
// rtl/ili9341_pixel_cursor.sv - x/y raster position with per-axis cell parity and last-pixel flag
module ili9341_pixel_cursor #(
   parameter int WIDTH  = 10,
   parameter int HEIGHT = 10,
   parameter int CELL   = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic advance,
   output logic x_odd,
   output logic y_odd,
   output logic last_pixel
);

   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [CW-1:0] cx;
   logic [CW-1:0] cy;
   logic          x_end;
   logic          y_end;
   logic          cx_end;
   logic          cy_end;

   assign x_end      = (x == XW'(WIDTH - 1));
   assign y_end      = (y == YW'(HEIGHT - 1));
   assign cx_end     = (cx == CW'(CELL - 1));
   assign cy_end     = (cy == CW'(CELL - 1));
   assign last_pixel = x_end && y_end;

   // x_odd / y_odd track the parity of x/CELL and y/CELL without any divider.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x     <= '0;
         y     <= '0;
         cx    <= '0;
         cy    <= '0;
         x_odd <= 1'b0;
         y_odd <= 1'b0;
      end else if (clear) begin
         x     <= '0;
         y     <= '0;
         cx    <= '0;
         cy    <= '0;
         x_odd <= 1'b0;
         y_odd <= 1'b0;
      end else if (advance) begin
         if (x_end) begin
            x     <= '0;
            cx    <= '0;
            x_odd <= 1'b0;
            if (y_end) begin
               y     <= '0;
               cy    <= '0;
               y_odd <= 1'b0;
            end else begin
               y <= y + 1'b1;
               if (cy_end) begin
                  cy    <= '0;
                  y_odd <= ~y_odd;
               end else begin
                  cy <= cy + 1'b1;
               end
            end
         end else begin
            x <= x + 1'b1;
            if (cx_end) begin
               cx    <= '0;
               x_odd <= ~x_odd;
            end else begin
               cx <= cx + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ili9341_frame_gen.sv
// rtl/ili9341_frame_gen.sv - frame-synchronous pixel source answering ili9341_controller pixel requests
module ili9341_frame_gen
   import ili9341_pkg::*;
#(
   parameter int WIDTH      = 10,
   parameter int HEIGHT     = 10,
   parameter int PIXEL_SIZE = 16,
   parameter int NUM_IMAGES = 5,
   parameter int SEL_W      = 3,
   parameter int CELL       = 2,
   parameter int REPEAT     = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SEL_W-1:0]      visua,
   input  logic [1:0]            mode,
   input  logic                  pixel_req,
   output logic [PIXEL_SIZE-1:0] pixel_data,
   output logic                  pixel_valid,
   output logic                  frame_start,
   output logic                  frame_done,
   output logic [SEL_W-1:0]      cur_sel
);

   state_t                state;
   logic [1:0]            mode_q;
   logic [PIXEL_SIZE-1:0] fg;
   logic                  x_odd;
   logic                  y_odd;
   logic                  last_pixel;
   logic                  clear;
   logic                  advance;
   logic                  use_bg;

   assign clear   = (state == ST_LOAD);
   assign advance = (state == ST_STREAM) && pixel_req;

   ili9341_pixel_cursor #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .CELL   (CELL)
   ) u_cursor (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .advance    (advance),
      .x_odd      (x_odd),
      .y_odd      (y_odd),
      .last_pixel (last_pixel)
   );

   always_comb begin
      use_bg = 1'b0;
      case (mode_q)
         MODE_STRIPES: use_bg = y_odd;
         MODE_CHECKER: use_bg = x_odd ^ y_odd;
         default:      use_bg = 1'b0;
      endcase
   end

   // Inputs are only sampled in LOAD and DONE, so a frame in flight never tears.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_LOAD;
         pixel_data  <= '0;
         pixel_valid <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         cur_sel     <= '0;
         mode_q      <= MODE_SOLID;
         fg          <= '0;
      end else begin
         pixel_valid <= 1'b0;
         frame_start <= 1'b0;
         case (state)
            ST_LOAD: begin
               cur_sel     <= visua;
               mode_q      <= mode;
               fg          <= PIXEL_SIZE'(mood_color(32'(visua), NUM_IMAGES));
               frame_done  <= 1'b0;
               frame_start <= 1'b1;
               state       <= ST_STREAM;
            end
            ST_STREAM: begin
               if (pixel_req) begin
                  pixel_data  <= use_bg ? ~fg : fg;
                  pixel_valid <= 1'b1;
                  if (last_pixel) begin
                     frame_done <= 1'b1;
                     state      <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (visua != cur_sel || mode != mode_q || REPEAT != 0)
                  state <= ST_LOAD;
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_ili9341_frame_gen.sv
// tb/tb_ili9341_frame_gen.sv - directed self-checking bench for ili9341_frame_gen
module tb_ili9341_frame_gen;

   logic        clk;
   logic        rst;
   logic [2:0]  visua;
   logic [1:0]  mode;
   logic        pixel_req;
   logic [15:0] pixel_data;
   logic        pixel_valid;
   logic        frame_start;
   logic        frame_done;
   logic [2:0]  cur_sel;

   int          total;
   int          passes;
   int          fails;
   logic [15:0] pix [100];

   ili9341_frame_gen #(
      .WIDTH      (10),
      .HEIGHT     (10),
      .PIXEL_SIZE (16),
      .NUM_IMAGES (5),
      .SEL_W      (3),
      .CELL       (2),
      .REPEAT     (0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .visua       (visua),
      .mode        (mode),
      .pixel_req   (pixel_req),
      .pixel_data  (pixel_data),
      .pixel_valid (pixel_valid),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .cur_sel     (cur_sel)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_color(input int sel, input int md, input int idx);
      logic [15:0] fgc;
      int          x;
      int          y;
      bit          odd;
      case (sel)
         0:       fgc = 16'hFFE0;
         1:       fgc = 16'h07FF;
         2:       fgc = 16'hF800;
         3:       fgc = 16'h780F;
         4:       fgc = 16'h0000;
         default: fgc = 16'h001F;
      endcase
      x = idx % 10;
      y = idx / 10;
      case (md)
         1:       odd = ((y / 2) % 2) != 0;
         2:       odd = (((x / 2) + (y / 2)) % 2) != 0;
         default: odd = 1'b0;
      endcase
      return odd ? ~fgc : fgc;
   endfunction

   task automatic expect_quiet(input string tag, input int cycles);
      int hits;
      hits = 0;
      pixel_req = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (pixel_valid || frame_start) hits++;
      end
      check(tag, 32'(hits), 32'd0);
   endtask

   task automatic run_frame(input string tag, input int sel, input int md, input bit gaps,
                            input int chg_idx, input logic [2:0] chg_sel, input int rev_idx,
                            input int abort_idx);
      int idx;
      int guard;
      pixel_req = 1'b1;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!frame_start && guard < 30);
      check({tag, "_start"}, 32'(frame_start), 32'd1);
      if (!frame_start) return;
      idx = 0;
      guard = 0;
      while (idx < 100 && guard < 400) begin
         pixel_req = gaps ? ~pixel_req : 1'b1;
         @(negedge clk);
         guard++;
         if (pixel_valid) begin
            pix[idx] = pixel_data;
            check($sformatf("%s_pix%0d", tag, idx), 32'(pixel_data), 32'(exp_color(sel, md, idx)));
            if (idx == 98) check({tag, "_done_early"}, 32'(frame_done), 32'd0);
            if (idx == 99) check({tag, "_done_last"}, 32'(frame_done), 32'd1);
            idx++;
            if (idx == chg_idx) visua = chg_sel;
            if (idx == rev_idx) visua = sel[2:0];
            if (idx == abort_idx) begin
               #2 rst = 1'b0;
               #1;
               check({tag, "_rst_valid"}, 32'(pixel_valid), 32'd0);
               check({tag, "_rst_data"}, 32'(pixel_data), 32'd0);
               check({tag, "_rst_done"}, 32'(frame_done), 32'd0);
               check({tag, "_rst_sel"}, 32'(cur_sel), 32'd0);
               @(negedge clk);
               check({tag, "_rst_hold"}, 32'(pixel_valid), 32'd0);
               rst = 1'b1;
               return;
            end
         end
      end
      check({tag, "_count"}, 32'(idx), 32'd100);
   endtask

   initial begin
      total     = 0;
      passes    = 0;
      fails     = 0;
      rst       = 1'b0;
      visua     = 3'd0;
      mode      = 2'd0;
      pixel_req = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", 32'(pixel_data), 32'd0);
      check("rst_valid", 32'(pixel_valid), 32'd0);
      check("rst_start", 32'(frame_start), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_sel", 32'(cur_sel), 32'd0);
      rst = 1'b1;

      // 1: solid IDLE frame, then hold with REPEAT=0
      run_frame("t1", 0, 0, 1'b0, -1, 3'd0, -1, -1);
      expect_quiet("t1_quiet", 30);
      check("t1_done_hold", 32'(frame_done), 32'd1);

      // 2: stripes with CARINO, requests every other cycle
      visua = 3'd2;
      mode  = 2'd1;
      run_frame("t2", 2, 1, 1'b1, -1, 3'd0, -1, -1);
      check("t2_row1_end", 32'(pix[19]), 32'h0000F800);
      check("t2_row2_beg", 32'(pix[20]), 32'h000007FF);
      check("t2_sel", 32'(cur_sel), 32'd2);

      // 3: checkerboard with TRISTE, hand-picked cells
      visua = 3'd1;
      mode  = 2'd2;
      run_frame("t3", 1, 2, 1'b0, -1, 3'd0, -1, -1);
      check("t3_p00", 32'(pix[0]), 32'h000007FF);
      check("t3_p20", 32'(pix[2]), 32'h0000F800);
      check("t3_p22", 32'(pix[22]), 32'h000007FF);
      check("t3_p11", 32'(pix[11]), 32'h000007FF);

      // 4: selector change mid-frame is deferred to the next frame
      visua = 3'd0;
      mode  = 2'd0;
      run_frame("t4a", 0, 0, 1'b0, 40, 3'd3, -1, -1);
      run_frame("t4b", 3, 0, 1'b0, -1, 3'd0, -1, -1);
      check("t4_sel", 32'(cur_sel), 32'd3);

      // 5: out-of-range selector, reverted change, mode 3 as solid
      visua = 3'd7;
      run_frame("t5a", 7, 0, 1'b0, -1, 3'd0, -1, -1);
      check("t5_sel7", 32'(cur_sel), 32'd7);
      visua = 3'd0;
      run_frame("t5b", 0, 0, 1'b0, 30, 3'd1, 60, -1);
      expect_quiet("t5_no_redraw", 30);
      check("t5_sel0", 32'(cur_sel), 32'd0);
      visua = 3'd4;
      mode  = 2'd3;
      run_frame("t5c", 4, 3, 1'b0, -1, 3'd0, -1, -1);

      // 6: asynchronous reset mid-frame, then a full frame from (0,0)
      visua = 3'd2;
      mode  = 2'd2;
      run_frame("t6a", 2, 2, 1'b0, -1, 3'd0, -1, 57);
      run_frame("t6b", 2, 2, 1'b0, -1, 3'd0, -1, -1);
      expect_quiet("t6_quiet", 20);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
